// File: rtl/thread_scheduler_pkg.sv
// Shared types and default sizing for the regex thread scheduler.
package thread_scheduler_pkg;
  localparam int PC_WIDTH_DEF        = 8;
  localparam int FIFO_DEPTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_e;
endpackage

// File: rtl/thread_scheduler_pc_fifo.sv
// Synchronous PC FIFO with same-cycle push/pop, clear, and a combinational head.
module thread_scheduler_pc_fifo
  import thread_scheduler_pkg::*;
#(
  parameter int WIDTH      = PC_WIDTH_DEF,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_r;
  logic [DEPTH_LOG2:0]   rd_ptr_r;
  logic [DEPTH_LOG2-1:0] wr_idx_s;

  // A clear restarts at slot 0, so a push alongside it lands there.
  assign wr_idx_s = clr ? {DEPTH_LOG2{1'b0}} : wr_ptr_r[DEPTH_LOG2-1:0];
  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign full     = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                    (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
  assign head     = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

  // Read/write pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
      rd_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {{DEPTH_LOG2{1'b0}}, push};
      rd_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end
endmodule

// File: rtl/thread_scheduler.sv
// Current/next PC queue scheduler for one regex engine.
// Optional CICERO_PC_DEDUP_EN drops duplicate PCs pushed to the next queue.
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int PC_WIDTH        = PC_WIDTH_DEF,
  parameter int FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                in_pc_valid,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                in_pc_to_current,
  output logic                in_pc_ready,
  output logic                out_pc_valid,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                out_pc_ready,
  input  logic                bb_accepts,
  input  logic                last_character,
  output logic                char_advance,
  output logic                busy,
  output logic                done,
  output logic                accepted
);
  sched_state_e        state_r;
  logic                cur_sel_r, busy_r, done_r, accepted_r;
  logic                a_full_s, a_empty_s, b_full_s, b_empty_s;
  logic [PC_WIDTH-1:0] a_head_s, b_head_s, cur_head_s, data_a_s;
  logic                cur_full_s, cur_empty_s, nxt_full_s, nxt_empty_s;
  logic                run_s, start_s, pop_s, dup_s;
  logic                push_hs_s, push_cur_s, push_nxt_s;
  logic                advance_s, adv_go_s;
  logic                push_a_s, push_b_s, pop_a_s, pop_b_s;

  // Map physical queues A/B onto current/next roles.
  always_comb begin
    if (cur_sel_r) begin
      cur_full_s  = b_full_s;
      cur_empty_s = b_empty_s;
      cur_head_s  = b_head_s;
      nxt_full_s  = a_full_s;
      nxt_empty_s = a_empty_s;
    end else begin
      cur_full_s  = a_full_s;
      cur_empty_s = a_empty_s;
      cur_head_s  = a_head_s;
      nxt_full_s  = b_full_s;
      nxt_empty_s = b_empty_s;
    end
  end

  assign run_s        = (state_r == S_RUN);
  assign start_s      = start && !run_s;
  assign out_pc_valid = run_s && !cur_empty_s;
  assign out_pc       = out_pc_valid ? cur_head_s : {PC_WIDTH{1'b0}};
  assign pop_s        = out_pc_valid && out_pc_ready;

  // Push acceptance; a full current queue still takes a push while it is being popped.
  always_comb begin
    in_pc_ready = 1'b0;
    if (!run_s) begin
      in_pc_ready = 1'b0;
    end else if (in_pc_to_current) begin
      in_pc_ready = !cur_full_s || pop_s;
    end else begin
      in_pc_ready = !nxt_full_s || dup_s;
    end
  end

  assign push_hs_s  = in_pc_valid && in_pc_ready;
  assign push_cur_s = push_hs_s && in_pc_to_current;
  assign push_nxt_s = push_hs_s && !in_pc_to_current && !dup_s;

  // The block is provably idle only with nothing queued, nothing moving, and ready high.
  assign advance_s    = run_s && !bb_accepts && cur_empty_s && !push_hs_s && !pop_s && out_pc_ready;
  assign adv_go_s     = advance_s && !nxt_empty_s && !last_character;
  assign char_advance = adv_go_s && !reset;

  assign push_a_s = start_s || (cur_sel_r ? push_nxt_s : push_cur_s);
  assign push_b_s = !start_s && (cur_sel_r ? push_cur_s : push_nxt_s);
  assign data_a_s = start_s ? start_pc : in_pc;
  assign pop_a_s  = pop_s && !cur_sel_r;
  assign pop_b_s  = pop_s && cur_sel_r;

`ifdef CICERO_PC_DEDUP_EN
  logic [(2**PC_WIDTH)-1:0] seen_r;

  assign dup_s = seen_r[in_pc];

  // PCs already queued for the next character.
  always_ff @(posedge clk) begin
    if (reset || start_s || adv_go_s) begin
      seen_r <= '0;
    end else if (push_nxt_s) begin
      seen_r[in_pc] <= 1'b1;
    end
  end
`else
  assign dup_s = 1'b0;
`endif

  thread_scheduler_pc_fifo #(.WIDTH(PC_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo_a (
    .clk(clk), .reset(reset), .clr(start_s), .push(push_a_s), .push_data(data_a_s),
    .pop(pop_a_s), .full(a_full_s), .empty(a_empty_s), .head(a_head_s)
  );

  thread_scheduler_pc_fifo #(.WIDTH(PC_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo_b (
    .clk(clk), .reset(reset), .clr(start_s), .push(push_b_s), .push_data(in_pc),
    .pop(pop_b_s), .full(b_full_s), .empty(b_empty_s), .head(b_head_s)
  );

  // Run-control state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cur_sel_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      accepted_r <= 1'b0;
    end else if (start_s) begin
      state_r    <= S_RUN;
      cur_sel_r  <= 1'b0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      accepted_r <= 1'b0;
    end else begin
      case (state_r)
        S_RUN: begin
          if (bb_accepts) begin
            state_r    <= S_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            accepted_r <= 1'b1;
          end else if (advance_s) begin
            if (nxt_empty_s || last_character) begin
              state_r    <= S_DONE;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              accepted_r <= 1'b0;
            end else begin
              cur_sel_r <= ~cur_sel_r;
            end
          end
        end
        S_IDLE, S_DONE: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign accepted = accepted_r;
endmodule
